// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing for the EX-stage divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } div_state_t;

  localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on the {rem, quo} work register
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0]   w,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W:0]   w_next
);

  logic [DATA_W:0] part;
  logic [DATA_W:0] diff;
  logic            take;

  // part is w[2W:W] after the left shift; a set w[2W] means it already exceeds any divisor
  assign part = w[2*DATA_W-1:DATA_W-1];
  assign diff = part - {1'b0, divisor};
  assign take = w[2*DATA_W] | (part >= {1'b0, divisor});

  always_comb begin
    w_next = {w[2*DATA_W-1:0], 1'b0};
    if (take) begin
      w_next = {diff, w[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - iterative DIV/DIVU unit: FSM, operand/sign latches, sign fix and stall request
module ex_div_unit
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_CYCLES
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   div_result,
  output logic                  div_ready,
  output logic                  div_stall
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_t            state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W:0]     w, w_step;
  logic [DATA_W-1:0]     divisor;
  logic                  q_neg, r_neg;

  logic                  sign1, sign2, start_ok, zero_div, last_step;
  logic [DATA_W-1:0]     abs1, abs2, quo, rem, quo_fix, rem_fix;

  assign sign1     = div_signed & opdata1[DATA_W-1];
  assign sign2     = div_signed & opdata2[DATA_W-1];
  assign abs1      = sign1 ? -opdata1 : opdata1;
  assign abs2      = sign2 ? -opdata2 : opdata2;
  assign start_ok  = div_start & ~annul;
  assign zero_div  = (opdata2 == '0);
  assign last_step = (cnt == CNT_W'(DATA_W - 1));

  assign quo     = w[DATA_W-1:0];
  assign rem     = w[2*DATA_W-1:DATA_W];
  assign quo_fix = q_neg ? -quo : quo;
  assign rem_fix = r_neg ? -rem : rem;

  div_step #(.DATA_W(DATA_W)) u_step (
    .w       (w),
    .divisor (divisor),
    .w_next  (w_step)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    div_stall  = 1'b0;
    div_ready  = 1'b0;
    div_result = '0;
    case (state)
      IDLE: begin
        div_stall = start_ok;
        if (start_ok) begin
          state_next = zero_div ? BYZERO : ON;
        end
      end
      BYZERO: begin
        div_stall  = ~annul;
        state_next = annul ? IDLE : END;
      end
      ON: begin
        div_stall = ~annul;
        if (annul) begin
          state_next = IDLE;
        end else if (last_step) begin
          state_next = END;
        end
      end
      END: begin
        div_ready  = 1'b1;
        div_result = {rem_fix, quo_fix};
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // keep the hazard unit released even if div_start is high during reset
    if (!resetn) begin
      div_stall = 1'b0;
    end
  end

  // A zero divisor preloads w with the final {opdata1, all-ones} pair and skips the sign fix
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      w       <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            cnt     <= '0;
            divisor <= abs2;
            if (zero_div) begin
              w     <= {1'b0, opdata1, {DATA_W{1'b1}}};
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              w     <= {{(DATA_W+1){1'b0}}, abs1};
              q_neg <= sign1 ^ sign2;
              r_neg <= sign1;
            end
          end
        end
        ON: begin
          w   <= w_step;
          cnt <= cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - scoreboard bench for ex_div_unit timing, signed/unsigned results, annul and reset
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic [63:0] div_result;
  logic        div_ready;
  logic        div_stall;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ex_div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_start  (div_start),
    .div_signed (div_signed),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .div_result (div_result),
    .div_ready  (div_ready),
    .div_stall  (div_stall)
  );

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Called at posedge+1 of cycle C; returns at posedge+1 of C+lat+1 (tail=0) or C+lat+2 (tail=1)
  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expv, input bit tail);
    int lat;
    logic [63:0] e;
    lat = (b == 32'd0) ? 2 : 33;
    exp_q.push_back(expv);
    div_signed = s;
    opdata1    = a;
    opdata2    = b;
    div_start  = 1'b1;
    for (int n = 0; n <= lat; n++) begin
      @(negedge clk);
      checks++;
      if (div_stall !== (n < lat)) begin
        errors++;
        $display("FAIL %s stall cyc %0d: got %b expected %b", name, n, div_stall, (n < lat));
      end
      checks++;
      if (div_ready !== (n == lat)) begin
        errors++;
        $display("FAIL %s ready cyc %0d: got %b expected %b", name, n, div_ready, (n == lat));
      end
      if (n == lat) begin
        e = exp_q.pop_front();
        checks++;
        if (div_result !== e) begin
          errors++;
          $display("FAIL %s result: got %h expected %h", name, div_result, e);
        end
      end else begin
        checks++;
        if (div_result !== 64'd0) begin
          errors++;
          $display("FAIL %s result-idle cyc %0d: got %h expected 0", name, n, div_result);
        end
      end
      @(posedge clk);
      #1;
      if (n == lat - 1) div_start = 1'b0;
    end
    if (tail) begin
      @(negedge clk);
      checks++;
      if (div_ready !== 1'b0 || div_result !== 64'd0) begin
        errors++;
        $display("FAIL %s after-end: got ready %b result %h expected 0 0", name, div_ready, div_result);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({div_stall, div_ready, div_result} !== 66'd0) begin
      errors++;
      $display("FAIL reset outputs: got %b %b %h expected 0", div_stall, div_ready, div_result);
    end
    div_start = 1'b1;
    opdata2   = 32'd5;
    #1;
    checks++;
    if (div_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset stall-gated: got %b expected 0", div_stall);
    end
    div_start = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b1);
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b1);
    run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 1'b1);
  endtask

  task automatic test_by_zero();
    run_div("byzero", 1'b0, 32'h12345678, 32'd0, {32'h12345678, 32'hFFFFFFFF}, 1'b1);
    run_div("byzero_neg", 1'b1, 32'hFFFFFFF0, 32'd0, {32'hFFFFFFF0, 32'hFFFFFFFF}, 1'b1);
  endtask

  task automatic test_annul();
    div_signed = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    div_start  = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
    end
    annul = 1'b1;
    @(negedge clk);
    checks++;
    if (div_stall !== 1'b0 || div_ready !== 1'b0) begin
      errors++;
      $display("FAIL annul C+10: got stall %b ready %b expected 0 0", div_stall, div_ready);
    end
    @(posedge clk);
    #1;
    annul     = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    checks++;
    if (div_stall !== 1'b0 || div_ready !== 1'b0) begin
      errors++;
      $display("FAIL annul C+11: got stall %b ready %b expected 0 0", div_stall, div_ready);
    end
    @(posedge clk);
    #1;
    run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b1);
  endtask

  task automatic test_reset_mid();
    div_signed = 1'b1;
    opdata1    = 32'hDEADBEEF;
    opdata2    = 32'd17;
    div_start  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (div_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid pre-stall: got %b expected 1", div_stall);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({div_stall, div_ready, div_result} !== 66'd0) begin
      errors++;
      $display("FAIL rst_mid async: got %b %b %h expected 0", div_stall, div_ready, div_result);
    end
    @(posedge clk);
    #1;
    div_start = 1'b0;
    resetn    = 1'b1;
    @(posedge clk);
    #1;
    run_div("after_reset", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic        s;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom();
      b = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300)));
      if (i == 5) begin
        s = 1'b1;
        b = 32'hFFFFFFFF;
      end
      run_div("b2b", s, a, b, model(s, a, b), (i == 9));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_by_zero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
